// File: rtl/display_pkg.sv
// Shared definitions for the display memory: controller state encoding and default geometry.
package display_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 13;

endpackage

// File: rtl/dp_ram_be.sv
// Dual-port word array: port A read-first with byte-masked writes, port B read-only.
// Both read ports are registered (1-cycle latency); reset clears only the output registers.
module dp_ram_be #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                a_en,
   input  logic                a_we,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic [DATA_W-1:0]   a_rdata,
   input  logic                b_en,
   input  logic [ADDR_W-1:0]   b_addr,
   output logic [DATA_W-1:0]   b_rdata
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int BE_W  = DATA_W/8;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
         end
      end
   end

   // Non-blocking reads sample the array before the same-edge write lands: read-first.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_en) a_rdata <= mem[a_addr];
         if (b_en) b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/display_ram_ctrl.sv
// Display memory controller: CPU byte-masked port, video read port, whole-array clear engine.
// Reads return 1 cycle after the strobe; CPU accesses are dropped while cpu_busy is high.
module display_ram_ctrl
   import display_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic                cpu_we,
   input  logic [DATA_W/8-1:0] cpu_be,
   input  logic                cpu_re,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                cpu_rvalid,
   output logic                cpu_busy,
   input  logic                clr_req,
   input  logic [DATA_W-1:0]   clr_value,
   output logic                clr_done,
   input  logic [ADDR_W-1:0]   vid_addr,
   input  logic                vid_en,
   output logic [DATA_W-1:0]   vid_data,
   output logic                vid_valid
);

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   fill;
   logic                clearing;
   logic                ram_we;
   logic                ram_re;
   logic [DATA_W/8-1:0] ram_be;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;

   assign clearing = (state == ST_CLEAR);
   assign cpu_busy = clearing;

   // Sweep owns port A while clearing; writes are held off during reset so an aborted sweep stops cleanly.
   assign ram_we    = !reset && (clearing || cpu_we);
   assign ram_re    = !clearing && cpu_re;
   assign ram_be    = clearing ? '1   : cpu_be;
   assign ram_addr  = clearing ? cnt  : cpu_addr;
   assign ram_wdata = clearing ? fill : cpu_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         cnt        <= '0;
         fill       <= '0;
         clr_done   <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_valid  <= 1'b0;
      end else begin
         clr_done   <= 1'b0;
         cpu_rvalid <= !clearing && cpu_re;
         vid_valid  <= vid_en;
         case (state)
            ST_IDLE: begin
               if (clr_req) begin
                  state <= ST_CLEAR;
                  fill  <= clr_value;
                  cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  state    <= ST_IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   dp_ram_be #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .reset  (reset),
      .a_en   (ram_re),
      .a_we   (ram_we),
      .a_be   (ram_be),
      .a_addr (ram_addr),
      .a_wdata(ram_wdata),
      .a_rdata(cpu_rdata),
      .b_en   (vid_en),
      .b_addr (vid_addr),
      .b_rdata(vid_data)
   );

endmodule

// File: tb/tb_display_ram_ctrl.sv
// Cycle-level reference model bench for display_ram_ctrl (16-word array, clear on reset).
module tb_display_ram_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_we;
   logic [1:0]    cpu_be;
   logic          cpu_re;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          cpu_busy;
   logic          clr_req;
   logic [DW-1:0] clr_value;
   logic          clr_done;
   logic [AW-1:0] vid_addr;
   logic          vid_en;
   logic [DW-1:0] vid_data;
   logic          vid_valid;

   display_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_be(cpu_be),
      .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
      .clr_req(clr_req), .clr_value(clr_value), .clr_done(clr_done),
      .vid_addr(vid_addr), .vid_en(vid_en), .vid_data(vid_data), .vid_valid(vid_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory image, remaining sweep words, fill word, expected registered outputs.
   logic [DW-1:0] m_mem [DEPTH];
   int            m_left  = 0;
   logic [DW-1:0] m_fill  = '0;
   bit            m_known = 1'b0;
   logic [DW-1:0] e_rdata = '0, e_vdata = '0;
   logic          e_rvalid = 1'b0, e_vvalid = 1'b0, e_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_be = '0; cpu_re = 1'b0;
      clr_req = 1'b0; clr_value = '0; vid_addr = '0; vid_en = 1'b0;
   endtask

   // One clock: predict from current inputs and model, clock the DUT, compare outputs.
   task automatic step();
      if (m_known) check("cpu_busy", cpu_busy, m_left > 0);
      if (reset) begin
         e_rdata = '0; e_vdata = '0; e_rvalid = 0; e_vvalid = 0; e_done = 0;
         m_left = DEPTH; m_fill = '0; m_known = 1'b1;
      end else begin
         e_vvalid = vid_en;
         if (vid_en) e_vdata = m_mem[vid_addr];
         e_done = 1'b0;
         if (m_left > 0) begin
            e_rvalid = 1'b0;
            m_mem[DEPTH - m_left] = m_fill;
            m_left--;
            e_done = (m_left == 0);
         end else begin
            e_rvalid = cpu_re;
            if (cpu_re) e_rdata = m_mem[cpu_addr];
            if (cpu_we) begin
               if (cpu_be[0]) m_mem[cpu_addr][7:0]  = cpu_wdata[7:0];
               if (cpu_be[1]) m_mem[cpu_addr][15:8] = cpu_wdata[15:8];
            end
            if (clr_req) begin
               m_left = DEPTH;
               m_fill = clr_value;
            end
         end
      end
      @(posedge clk);
      #1;
      check("cpu_rdata",  cpu_rdata,  e_rdata);
      check("cpu_rvalid", cpu_rvalid, e_rvalid);
      check("vid_data",   vid_data,   e_vdata);
      check("vid_valid",  vid_valid,  e_vvalid);
      check("clr_done",   clr_done,   e_done);
   endtask

   // Steps idle cycles while the DUT is busy; returns the number of busy cycles seen (bounded).
   task automatic run_busy(output int n);
      n = 0;
      while (cpu_busy && n < 4*DEPTH) begin
         step();
         n++;
      end
   endtask

   task automatic read_all(input bit use_vid);
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         cpu_re = 1'b1; cpu_addr = AW'(i);
         vid_en = use_vid; vid_addr = AW'(DEPTH - 1 - i);
         step();
      end
      idle_inputs();
   endtask

   int nb;

   initial begin
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      step();
      check("reset_rdata", cpu_rdata, 0);
      check("reset_done",  clr_done, 0);
      check("busy_in_reset", cpu_busy, 1);
      idle_inputs();
      run_busy(nb);
      check("reset_clear_cycles", nb, DEPTH);
      step();
      read_all(1'b1);

      // Byte-masked writes then read back
      idle_inputs(); cpu_we = 1; cpu_addr = 5; cpu_wdata = 16'hBEEF; cpu_be = 2'b11; step();
      idle_inputs(); cpu_we = 1; cpu_addr = 5; cpu_wdata = 16'h1234; cpu_be = 2'b01; step();
      idle_inputs(); cpu_we = 1; cpu_addr = 5; cpu_wdata = 16'h5555; cpu_be = 2'b00; step();
      idle_inputs(); cpu_re = 1; cpu_addr = 5; step();
      check("be_merge", cpu_rdata, 16'hBE34);
      check("be_rvalid", cpu_rvalid, 1);
      idle_inputs(); step();
      check("rvalid_pulse", cpu_rvalid, 0);

      // Read-first on same-cycle write and read
      idle_inputs(); cpu_we = 1; cpu_re = 1; cpu_addr = 7; cpu_wdata = 16'hAAAA; cpu_be = 2'b11; step();
      check("rf_old", cpu_rdata, 16'h0000);
      idle_inputs(); cpu_re = 1; cpu_addr = 7; step();
      check("rf_new", cpu_rdata, 16'hAAAA);

      // Clear with fill word, CPU write attempted mid-clear, clr_req retrigger ignored
      idle_inputs(); clr_req = 1; clr_value = 16'h0720; step();
      nb = 0;
      for (int i = 0; i < 6 && cpu_busy; i++) begin idle_inputs(); step(); nb++; end
      idle_inputs(); cpu_we = 1; cpu_re = 1; cpu_addr = 3; cpu_wdata = 16'hDEAD; cpu_be = 2'b11;
      clr_req = 1; clr_value = 16'h1111; step(); nb++;
      check("busy_rvalid", cpu_rvalid, 0);
      idle_inputs();
      begin int rest; run_busy(rest); nb += rest; end
      check("clear_cycles", nb, DEPTH);
      step();
      read_all(1'b0);
      idle_inputs(); cpu_re = 1; cpu_addr = 3; step();
      check("fill_word3", cpu_rdata, 16'h0720);

      // Video streaming with concurrent CPU writes (collisions exercise read-first)
      for (int i = 0; i < 2*DEPTH; i++) begin
         idle_inputs();
         vid_en = 1; vid_addr = AW'(i);
         cpu_we = 1; cpu_be = 2'($urandom_range(0, 3));
         cpu_addr = (i % 3 == 0) ? AW'(i) : AW'($urandom);
         cpu_wdata = DW'($urandom);
         step();
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom); cpu_be = 2'($urandom);
         cpu_we = ($urandom_range(0, 2) == 0); cpu_re = ($urandom_range(0, 1) == 0);
         vid_en = ($urandom_range(0, 3) != 0); vid_addr = AW'($urandom);
         clr_req = ($urandom_range(0, 39) == 0); clr_value = DW'($urandom);
         step();
      end
      idle_inputs();
      run_busy(nb);
      step();

      // Reset at sweep word 8 aborts the clear and restarts with fill 0
      idle_inputs(); clr_req = 1; clr_value = 16'h3C3C; step();
      for (int i = 0; i < 8; i++) begin idle_inputs(); vid_en = 1; vid_addr = AW'(i); step(); end
      idle_inputs(); reset = 1; vid_en = 1; step();
      check("abort_vid_valid", vid_valid, 0);
      check("abort_vid_data", vid_data, 0);
      idle_inputs();
      run_busy(nb);
      check("restart_clear_cycles", nb, DEPTH);
      step();
      read_all(1'b1);
      idle_inputs(); cpu_re = 1; cpu_addr = 12; step();
      check("restart_fill", cpu_rdata, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
